// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the round-robin adder arbiter.
// Holds the controller state encoding, the default requester count and operand width,
// and the helper that sizes the requester index.
package adder_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StResp
    } state_e;

    localparam int unsigned NumReqDefault = 4;
    localparam int unsigned WidthDefault  = 32;

    // A single requester still needs a 1-bit id field.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    localparam int unsigned IdWidth = id_width(NumReqDefault);

endpackage

// File: rtl/adder_arbiter_plus_adder.sv
// PlusAdder: unsigned ripple-carry adder.
// Ports:
//   add1_i  [WIDTH-1:0]  first operand
//   add2_i  [WIDTH-1:0]  second operand
//   sum_o   [WIDTH-1:0]  add1_i + add2_i, modulo 2^WIDTH
//   carry_o              carry out of the top bit
module PlusAdder
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    always_comb begin
        logic c;
        c     = 1'b0;
        sum_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum_o[i] = add1_i[i] ^ add2_i[i] ^ c;
            c        = (add1_i[i] & add2_i[i]) | (c & (add1_i[i] ^ add2_i[i]));
        end
        carry_o = c;
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: NUM_REQ requesters share one adder through a round-robin arbiter.
// A granted request is captured in IDLE, added in CALC and presented in RESP until taken.
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_valid_i          per-requester request
//   req_a_i, req_b_i     packed operands, requester k at [k*WIDTH +: WIDTH]
//   req_ready_o          one-hot grant, combinational in IDLE
//   rsp_valid_o          result available (RESP)
//   rsp_ready_i          consumer accepts result
//   rsp_id_o             index of the requester owning the result
//   rsp_sum_o            A+B modulo 2^WIDTH
//   rsp_carry_o          carry out of the sum
//   busy_o               controller not in IDLE
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = NumReqDefault,
    parameter int unsigned WIDTH   = WidthDefault
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0]      req_b_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [id_width(NUM_REQ)-1:0]  rsp_id_o,
    output logic [WIDTH-1:0]              rsp_sum_o,
    output logic                          rsp_carry_o,
    output logic                          busy_o
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    state_e             state_q, state_d;
    logic [IdW-1:0]     last_q, last_d;
    logic [IdW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic               grant_any;
    logic [IdW-1:0]     grant_idx;
    logic [NUM_REQ*WIDTH-1:0] a_shift, b_shift;
    logic [WIDTH-1:0]   add_sum;
    logic               add_carry;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int unsigned cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(last_q) + i + 1) % NUM_REQ;
            if (!grant_any && ((req_valid_i >> cand) & NUM_REQ'(1)) != '0) begin
                grant_any = 1'b1;
                grant_idx = IdW'(cand);
            end
        end
    end

    // Shift the winner's operands down to the bottom slice.
    assign a_shift = req_a_i >> (32'(grant_idx) * WIDTH);
    assign b_shift = req_b_i >> (32'(grant_idx) * WIDTH);

    PlusAdder #(
        .WIDTH (WIDTH)
    ) u_plus_adder (
        .add1_i  (a_q),
        .add2_i  (b_q),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        req_ready_o = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_any && rst_ni) begin
                    req_ready_o = NUM_REQ'(1) << grant_idx;
                    last_d      = grant_idx;
                    id_d        = grant_idx;
                    a_d         = a_shift[WIDTH-1:0];
                    b_d         = b_shift[WIDTH-1:0];
                    state_d     = StCalc;
                end
            end
            StCalc: begin
                sum_d   = add_sum;
                carry_d = add_carry;
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            last_q  <= IdW'(NUM_REQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign rsp_valid_o = (state_q == StResp);
    assign busy_o      = (state_q != StIdle);
    assign rsp_id_o    = id_q;
    assign rsp_sum_o   = sum_q;
    assign rsp_carry_o = carry_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter: constant vector table, directed corner
// sequences and random traffic against a transaction-level reference model.
module tb_adder_arbiter;
    import adder_arbiter_pkg::*;

    localparam int N = 4;
    localparam int W = 32;

    logic               clk;
    logic               rst_n;
    logic [N-1:0]       req_valid;
    logic [N*W-1:0]     req_a, req_b;
    logic [N-1:0]       req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IdWidth-1:0] rsp_id;
    logic [W-1:0]       rsp_sum;
    logic               rsp_carry;
    logic               busy;

    adder_arbiter #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_ready_o (req_ready),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_sum_o   (rsp_sum),
        .rsp_carry_o (rsp_carry),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: one outstanding transaction and its age in cycles since grant.
    bit          m_txn  = 1'b0;
    int          m_age  = 0;
    int          m_id   = 0;
    int          m_last = N - 1;
    logic [W:0]  m_res  = '0;
    int          dut_grant;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        int g;
        logic [N-1:0] exp_ready;
        logic [W-1:0] ga, gb;
        @(negedge clk);
        g = -1;
        if (rst_n && !m_txn) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_last + 1 + i) % N;
                if (g < 0 && req_valid[k]) g = k;
            end
        end
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(m_txn && m_age == 2));
        chk("busy", 64'(busy), 64'(m_txn));
        if (m_txn && m_age == 2) begin
            chk("rsp_id", 64'(rsp_id), 64'(m_id));
            chk("rsp_sum", 64'(rsp_sum), 64'(m_res[W-1:0]));
            chk("rsp_carry", 64'(rsp_carry), 64'(m_res[W]));
        end
        dut_grant = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) dut_grant = i;
        @(posedge clk);
        if (!rst_n) begin
            m_txn  = 1'b0;
            m_last = N - 1;
        end else if (g >= 0) begin
            ga     = req_a[g*W +: W];
            gb     = req_b[g*W +: W];
            m_txn  = 1'b1;
            m_age  = 1;
            m_id   = g;
            m_last = g;
            m_res  = {1'b0, ga} + {1'b0, gb};
        end else if (m_txn) begin
            if (m_age == 2) begin
                if (rsp_ready) m_txn = 1'b0;
            end else begin
                m_age = 2;
            end
        end
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (3) cycle();
    endtask

    typedef struct {
        int          id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         carry;
    } vec_t;

    vec_t tbl[6];
    int   grants[$];
    int   gcyc[$];
    logic [W-1:0] held_sum;
    logic [IdWidth-1:0] held_id;
    int   exp_order[5];

    initial begin
        tbl[0] = '{0, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0};
        tbl[1] = '{0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        tbl[2] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1};
        tbl[3] = '{2, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
        tbl[4] = '{1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        tbl[5] = '{3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
        exp_order = '{0, 1, 2, 3, 0};

        // Reset with requests pending: no grant may leak out.
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '1;
        req_b     = '1;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_valid", 64'(rsp_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_sum", 64'(rsp_sum), 64'(0));
        chk("rst_carry", 64'(rsp_carry), 64'(0));
        chk("rst_id", 64'(rsp_id), 64'(0));
        req_valid = '0;
        rst_n     = 1'b1;

        // Table: single requester; operands scrambled after the grant cycle.
        for (int i = 0; i < 6; i++) begin
            req_valid = N'(1 << tbl[i].id);
            req_a[tbl[i].id*W +: W] = tbl[i].a;
            req_b[tbl[i].id*W +: W] = tbl[i].b;
            rsp_ready = 1'b1;
            cycle();
            chk("tbl_grant", 64'(dut_grant), 64'(tbl[i].id));
            req_valid = '0;
            req_a     = {$urandom, $urandom, $urandom, $urandom};
            req_b     = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            chk("tbl_valid", 64'(rsp_valid), 64'(1));
            chk("tbl_id", 64'(rsp_id), 64'(tbl[i].id));
            chk("tbl_sum", 64'(rsp_sum), 64'(tbl[i].sum));
            chk("tbl_carry", 64'(rsp_carry), 64'(tbl[i].carry));
            cycle();
        end

        // All requesters valid after reset: 0,1,2,3,0 spaced by 3 cycles.
        rst_n = 1'b0;
        cycle();
        rst_n     = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int c = 0; c < 13; c++) begin
            req_a = {$urandom, $urandom, $urandom, $urandom};
            req_b = {$urandom, $urandom, $urandom, $urandom};
            cycle();
            if (dut_grant >= 0) begin
                grants.push_back(dut_grant);
                gcyc.push_back(c);
            end
        end
        chk("rr_count", 64'(grants.size()), 64'(5));
        for (int i = 0; i < 5 && i < grants.size(); i++) begin
            chk("rr_order", 64'(grants[i]), 64'(exp_order[i]));
            chk("rr_spacing", 64'(gcyc[i]), 64'(3 * i));
        end

        // Backpressure: hold RESP for 5 cycles, grant right after the handshake.
        drain();
        req_valid = '1;
        rsp_ready = 1'b0;
        for (int c = 0; c < 4 && !rsp_valid; c++) cycle();
        chk("bp_reach_resp", 64'(rsp_valid), 64'(1));
        held_sum = rsp_sum;
        held_id  = rsp_id;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("bp_sum_stable", 64'(rsp_sum), 64'(held_sum));
            chk("bp_id_stable", 64'(rsp_id), 64'(held_id));
            chk("bp_no_grant", 64'(dut_grant), -64'sd1);
        end
        rsp_ready = 1'b1;
        cycle();
        cycle();
        chk("bp_grant_after", 64'(dut_grant >= 0), 64'(1));

        // Reset during CALC abandons the operation; requester 0 wins next.
        drain();
        req_valid = 4'b0110;
        cycle();
        chk("mid_grant", 64'(dut_grant), 64'(1));
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mid_valid", 64'(rsp_valid), 64'(0));
        chk("mid_busy", 64'(busy), 64'(0));
        req_valid = 4'b0101;
        cycle();
        chk("mid_next_grant", 64'(dut_grant), 64'(0));

        // Wrap-around: last grant 3, then only 3 and 1 valid -> 1, then 3.
        drain();
        req_valid = 4'b1000;
        cycle();
        chk("wrap_first", 64'(dut_grant), 64'(3));
        req_valid = '0;
        cycle();
        cycle();
        req_valid = 4'b1010;
        cycle();
        chk("wrap_second", 64'(dut_grant), 64'(1));
        cycle();
        cycle();
        cycle();
        chk("wrap_third", 64'(dut_grant), 64'(3));

        // Random traffic with occasional reset pulses.
        for (int c = 0; c < 500; c++) begin
            req_valid = N'($urandom);
            for (int k = 0; k < N; k++) begin
                req_a[k*W +: W] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
                req_b[k*W +: W] = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            rst_n     = ($urandom_range(0, 59) != 0);
            cycle();
        end
        rst_n = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
